// File: rtl/sync_fifo_if.sv
// sync_fifo_if: handshake and status bundle for sync_fifo.
//   slave  modport - FIFO side (consumes requests, drives data/status)
//   master modport - user side (drives requests, consumes data/status)
// Signals: i_clr, i_wdata, i_w_en, i_r_en in; o_rdata, o_rvalid,
// o_wfull_flag, o_rempty_flag, o_almost_full, o_almost_empty, o_count,
// o_overflow, o_underflow out (directions as seen by the FIFO).
interface sync_fifo_if #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
);
    logic                i_clr;
    logic [DATASIZE-1:0] i_wdata;
    logic                i_w_en;
    logic                i_r_en;
    logic [DATASIZE-1:0] o_rdata;
    logic                o_rvalid;
    logic                o_wfull_flag;
    logic                o_rempty_flag;
    logic                o_almost_full;
    logic                o_almost_empty;
    logic [ADDRSIZE:0]   o_count;
    logic                o_overflow;
    logic                o_underflow;

    modport slave (
        input  i_clr, i_wdata, i_w_en, i_r_en,
        output o_rdata, o_rvalid, o_wfull_flag, o_rempty_flag,
               o_almost_full, o_almost_empty, o_count, o_overflow, o_underflow
    );

    modport master (
        output i_clr, i_wdata, i_w_en, i_r_en,
        input  o_rdata, o_rvalid, o_wfull_flag, o_rempty_flag,
               o_almost_full, o_almost_empty, o_count, o_overflow, o_underflow
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, DEPTH = 2**ADDRSIZE words of DATASIZE bits.
// Ports:
//   i_clk - clock, rising edge
//   i_rst - asynchronous active-high reset
//   bus   - sync_fifo_if.slave (requests in, data and registered status out)
// FWFT=0 gives a registered read (data one cycle after the accepted read,
// o_rvalid pulses with it); FWFT=1 presents the head word while non-empty.
// All status outputs are registered from the next-state values, so they
// describe the FIFO right after each edge. Overflow/underflow are sticky
// until i_clr or i_rst.
module sync_fifo #(
    parameter int DATASIZE  = 8,
    parameter int ADDRSIZE  = 4,
    parameter int AFULL_TH  = 14,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic      i_clk,
    input  logic      i_rst,
    sync_fifo_if.slave bus
);
    localparam int DEPTH = 2 ** ADDRSIZE;
    localparam int PW    = ADDRSIZE + 1;

    logic [DATASIZE-1:0] mem [DEPTH];
    logic [PW-1:0]       wptr, rptr, cnt;
    logic [PW-1:0]       wptr_nxt, rptr_nxt, cnt_nxt;
    logic                wr_acc, rd_acc, full_nxt, empty_nxt;

    // Acceptance uses the registered (pre-edge) flags, so a read cannot
    // free space for a same-cycle write, nor a write feed a same-cycle read.
    always_comb begin
        wr_acc   = bus.i_w_en && !bus.o_wfull_flag  && !bus.i_clr;
        rd_acc   = bus.i_r_en && !bus.o_rempty_flag && !bus.i_clr;
        wptr_nxt = wptr;
        rptr_nxt = rptr;
        cnt_nxt  = cnt;
        if (bus.i_clr) begin
            wptr_nxt = '0;
            rptr_nxt = '0;
            cnt_nxt  = '0;
        end else begin
            wptr_nxt = wptr + PW'(wr_acc);
            rptr_nxt = rptr + PW'(rd_acc);
            cnt_nxt  = cnt + PW'(wr_acc) - PW'(rd_acc);
        end
        // Pointers run modulo 2*DEPTH: the extra MSB tells full from empty.
        empty_nxt = (wptr_nxt == rptr_nxt);
        full_nxt  = (wptr_nxt[PW-1] != rptr_nxt[PW-1]) &&
                    (wptr_nxt[PW-2:0] == rptr_nxt[PW-2:0]);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr               <= '0;
            rptr               <= '0;
            cnt                <= '0;
            bus.o_wfull_flag   <= 1'b0;
            bus.o_rempty_flag  <= 1'b1;
            bus.o_almost_full  <= 1'b0;
            bus.o_almost_empty <= 1'b1;
            bus.o_overflow     <= 1'b0;
            bus.o_underflow    <= 1'b0;
        end else begin
            wptr               <= wptr_nxt;
            rptr               <= rptr_nxt;
            cnt                <= cnt_nxt;
            bus.o_wfull_flag   <= full_nxt;
            bus.o_rempty_flag  <= empty_nxt;
            bus.o_almost_full  <= (cnt_nxt >= PW'(AFULL_TH));
            bus.o_almost_empty <= (cnt_nxt <= PW'(AEMPTY_TH));
            if (bus.i_clr) begin
                bus.o_overflow  <= 1'b0;
                bus.o_underflow <= 1'b0;
            end else begin
                if (bus.i_w_en && bus.o_wfull_flag)  bus.o_overflow  <= 1'b1;
                if (bus.i_r_en && bus.o_rempty_flag) bus.o_underflow <= 1'b1;
            end
        end
    end

    assign bus.o_count = cnt;

    // Storage is deliberately not reset; the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (wr_acc) mem[wptr[PW-2:0]] <= bus.i_wdata;
    end

    generate
        if (FWFT == 0) begin : g_std
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    bus.o_rdata  <= '0;
                    bus.o_rvalid <= 1'b0;
                end else begin
                    bus.o_rvalid <= rd_acc;
                    if (rd_acc) bus.o_rdata <= mem[rptr[PW-2:0]];
                end
            end
        end else begin : g_fwft
            // Gate with empty so stale/unreset storage never shows up on the bus.
            assign bus.o_rdata  = bus.o_rempty_flag ? '0 : mem[rptr[PW-2:0]];
            assign bus.o_rvalid = !bus.o_rempty_flag;
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: drives identical stimulus into a standard-read and an FWFT
// instance of sync_fifo and checks both every cycle against a queue model,
// plus directed literal checks on the key scenarios.
module tb_sync_fifo;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam int AFT = 14;
    localparam int AET = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   run = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sync_fifo_if #(.DATASIZE(DW), .ADDRSIZE(AW)) if0 ();
    sync_fifo_if #(.DATASIZE(DW), .ADDRSIZE(AW)) if1 ();

    sync_fifo #(.DATASIZE(DW), .ADDRSIZE(AW), .AFULL_TH(AFT), .AEMPTY_TH(AET), .FWFT(0))
        dut0 (.i_clk(clk), .i_rst(rst), .bus(if0));
    sync_fifo #(.DATASIZE(DW), .ADDRSIZE(AW), .AFULL_TH(AFT), .AEMPTY_TH(AET), .FWFT(1))
        dut1 (.i_clk(clk), .i_rst(rst), .bus(if1));

    // ---------------- behavioural model ----------------
    logic [DW-1:0] q[$];
    bit            m_ovf, m_unf, m_rv0;
    logic [DW-1:0] m_rd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_ovf = 0; m_unf = 0; m_rv0 = 0; m_rd0 = '0;
        end else if (if0.i_clr) begin
            q.delete();
            m_ovf = 0; m_unf = 0; m_rv0 = 0;
        end else begin
            bit full, empty, wr, rd;
            full  = (q.size() == DEPTH);
            empty = (q.size() == 0);
            wr = if0.i_w_en && !full;
            rd = if0.i_r_en && !empty;
            if (if0.i_w_en && full)  m_ovf = 1;
            if (if0.i_r_en && empty) m_unf = 1;
            m_rv0 = rd;
            if (rd) m_rd0 = q.pop_front();
            if (wr) q.push_back(if0.i_wdata);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (run && !rst) begin
            int n;
            n = q.size();
            chk("count0",  32'(if0.o_count), 32'(n));
            chk("count1",  32'(if1.o_count), 32'(n));
            chk("full0",   32'(if0.o_wfull_flag),   32'(n == DEPTH));
            chk("full1",   32'(if1.o_wfull_flag),   32'(n == DEPTH));
            chk("empty0",  32'(if0.o_rempty_flag),  32'(n == 0));
            chk("empty1",  32'(if1.o_rempty_flag),  32'(n == 0));
            chk("afull0",  32'(if0.o_almost_full),  32'(n >= AFT));
            chk("aempty0", 32'(if0.o_almost_empty), 32'(n <= AET));
            chk("afull1",  32'(if1.o_almost_full),  32'(n >= AFT));
            chk("aempty1", 32'(if1.o_almost_empty), 32'(n <= AET));
            chk("ovf0",    32'(if0.o_overflow),  32'(m_ovf));
            chk("unf0",    32'(if0.o_underflow), 32'(m_unf));
            chk("ovf1",    32'(if1.o_overflow),  32'(m_ovf));
            chk("unf1",    32'(if1.o_underflow), 32'(m_unf));
            chk("rvalid0", 32'(if0.o_rvalid), 32'(m_rv0));
            chk("rdata0",  32'(if0.o_rdata),  32'(m_rd0));
            chk("rvalid1", 32'(if1.o_rvalid), 32'(n != 0));
            if (n != 0) chk("rdata1", 32'(if1.o_rdata), 32'(q[0]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input logic w, input logic r, input logic [DW-1:0] d, input logic c);
        if0.i_w_en = w; if0.i_r_en = r; if0.i_wdata = d; if0.i_clr = c;
        if1.i_w_en = w; if1.i_r_en = r; if1.i_wdata = d; if1.i_clr = c;
    endtask

    task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic c);
        set_in(w, r, d, c);
        @(negedge clk);
    endtask

    initial begin
        int wp;
        set_in(0, 0, '0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run = 1'b1;
        // reset state
        chk("rst_count", 32'(if0.o_count), 0);
        chk("rst_empty", 32'(if0.o_rempty_flag), 1);
        chk("rst_aempty", 32'(if0.o_almost_empty), 1);
        chk("rst_rdata0", 32'(if0.o_rdata), 0);
        chk("rst_rdata1", 32'(if1.o_rdata), 0);
        chk("rst_rvalid1", 32'(if1.o_rvalid), 0);

        // fill 0x00..0x0F, almost-full from count 14, then overflow
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 8'(i), 0);
            chk("fill_afull", 32'(if0.o_almost_full), 32'(i + 1 >= 14));
        end
        chk("fill_count", 32'(if0.o_count), 16);
        chk("fill_full", 32'(if0.o_wfull_flag), 1);
        step(1, 0, 8'hAA, 0);
        chk("ovf_set", 32'(if0.o_overflow), 1);
        chk("ovf_count", 32'(if0.o_count), 16);

        // drain with registered read
        for (int i = 0; i < 16; i++) begin
            step(0, 1, '0, 0);
            chk("drain_rdata", 32'(if0.o_rdata), 32'(i));
            chk("drain_rvalid", 32'(if0.o_rvalid), 1);
        end
        chk("drain_empty", 32'(if0.o_rempty_flag), 1);
        step(0, 1, '0, 0);
        chk("unf_set", 32'(if0.o_underflow), 1);
        chk("unf_rvalid", 32'(if0.o_rvalid), 0);

        // steady state at count 8 across pointer wrap
        step(0, 0, '0, 1);
        for (int i = 0; i < 8; i++) step(1, 0, 8'($urandom), 0);
        for (int i = 0; i < 40; i++) step(1, 1, 8'($urandom), 0);
        chk("wrap_count", 32'(if0.o_count), 8);

        // full + simultaneous r/w: write rejected
        step(0, 0, '0, 1);
        for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h40 + i), 0);
        step(1, 1, 8'hEE, 0);
        chk("fullrw_count", 32'(if0.o_count), 15);
        chk("fullrw_ovf", 32'(if0.o_overflow), 1);
        chk("fullrw_rdata", 32'(if0.o_rdata), 32'h40);
        // empty + simultaneous r/w: read rejected
        step(0, 0, '0, 1);
        step(1, 1, 8'h11, 0);
        chk("emptyrw_count", 32'(if0.o_count), 1);
        chk("emptyrw_unf", 32'(if0.o_underflow), 1);
        chk("emptyrw_head", 32'(if1.o_rdata), 32'h11);

        // FWFT single word
        step(0, 0, '0, 1);
        step(1, 0, 8'h5A, 0);
        chk("fwft_rdata", 32'(if1.o_rdata), 32'h5A);
        chk("fwft_rvalid", 32'(if1.o_rvalid), 1);
        step(0, 1, '0, 0);
        chk("fwft_empty", 32'(if1.o_rempty_flag), 1);
        chk("fwft_rvalid_lo", 32'(if1.o_rvalid), 0);

        // clear with errors set at count 5
        step(0, 0, '0, 1);
        step(0, 1, '0, 0);
        for (int i = 0; i < 17; i++) step(1, 0, 8'($urandom), 0);
        for (int i = 0; i < 11; i++) step(0, 1, '0, 0);
        chk("pre_clr_count", 32'(if0.o_count), 5);
        step(0, 0, '0, 1);
        chk("clr_count", 32'(if0.o_count), 0);
        chk("clr_empty", 32'(if0.o_rempty_flag), 1);
        chk("clr_ovf", 32'(if0.o_overflow), 0);
        chk("clr_unf", 32'(if0.o_underflow), 0);

        // randomized traffic with shifting write bias and rare clears
        wp = 50;
        for (int k = 0; k < 900; k++) begin
            if (k % 60 == 0) wp = 15 + 35 * int'($urandom_range(2));
            step(32'($urandom_range(99)) < 32'(wp),
                 32'($urandom_range(99)) < 32'(100 - wp),
                 8'($urandom), $urandom_range(99) == 0);
        end

        // asynchronous reset between edges during a write burst
        step(0, 0, '0, 1);
        step(1, 0, 8'hC3, 0);
        step(0, 1, '0, 0);
        chk("pre_rst_rdata", 32'(if0.o_rdata), 32'hC3);
        step(1, 0, 8'h21, 0);
        set_in(1, 0, 8'h33, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 32'(if0.o_count), 0);
        chk("arst_empty", 32'(if0.o_rempty_flag), 1);
        chk("arst_aempty", 32'(if0.o_almost_empty), 1);
        chk("arst_full", 32'(if0.o_wfull_flag), 0);
        chk("arst_afull", 32'(if0.o_almost_full), 0);
        chk("arst_ovf", 32'(if0.o_overflow), 0);
        chk("arst_unf", 32'(if0.o_underflow), 0);
        chk("arst_rvalid0", 32'(if0.o_rvalid), 0);
        chk("arst_rdata0", 32'(if0.o_rdata), 0);
        chk("arst_rvalid1", 32'(if1.o_rvalid), 0);
        set_in(0, 0, '0, 0);
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 8'h77, 0);
        chk("post_rst_count", 32'(if1.o_count), 1);
        chk("post_rst_head", 32'(if1.o_rdata), 32'h77);
        step(0, 1, '0, 0);
        chk("post_rst_rdata0", 32'(if0.o_rdata), 32'h77);

        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
